// File: rtl/reaction_ctrl_if.sv
// Button-side and display-side signals of the reaction timer trial sequencer.
// The controller takes the slave view; the stimulus/debounce side takes the master view.
interface reaction_ctrl_if;
   logic        start;
   logic        react;
   logic        clear_best;
   logic        led;
   logic        foul;
   logic        timeout;
   logic        result_valid;
   logic [15:0] time_bcd;
   logic [15:0] best_bcd;
   logic [2:0]  state;

   modport master (
      output start, react, clear_best,
      input  led, foul, timeout, result_valid, time_bcd, best_bcd, state
   );

   modport slave (
      input  start, react, clear_best,
      output led, foul, timeout, result_valid, time_bcd, best_bcd, state
   );
endinterface

// File: rtl/reaction_ctrl.sv
// Reaction timer trial sequencer: random hold-off, stimulus lamp, BCD millisecond
// count of the reaction, and the best (lowest) valid time.
module reaction_ctrl #(
   parameter int TICKS_PER_MS = 50000,
   parameter int MIN_DELAY_MS = 1000
) (
   input  logic           clk,
   input  logic           reset,
   reaction_ctrl_if.slave bus
);

   localparam int          CNT_W     = $clog2(TICKS_PER_MS);
   localparam int          DLY_W     = $clog2(MIN_DELAY_MS + 2048);
   localparam logic [15:0] BCD_MAX   = 16'h9999;
   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WAIT  = 3'd1,
      S_ARMED = 3'd2,
      S_DONE  = 3'd3,
      S_FOUL  = 3'd4
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [DLY_W-1:0]   delay_q, delay_d;
   logic [15:0]        lfsr_q, lfsr_d;
   logic [15:0]        time_q, time_d;
   logic [15:0]        best_q, best_d;
   logic               led_q, led_d;
   logic               foul_q, foul_d;
   logic               timeout_q, timeout_d;
   logic               rv_q, rv_d;
   logic               tick;

   // Fibonacci form, taps 16,14,13,11; a non-zero seed keeps it off the all-zero lock-up state.
   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (r[i*4 +: 4] == 4'd9) begin
               r[i*4 +: 4] = 4'd0;
            end else begin
               r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   assign tick = (cnt_q == CNT_W'(TICKS_PER_MS - 1));

   always_comb begin
      state_d   = state_q;
      delay_d   = delay_q;
      time_d    = time_q;
      best_d    = bus.clear_best ? BCD_MAX : best_q;
      led_d     = led_q;
      foul_d    = foul_q;
      timeout_d = timeout_q;
      rv_d      = 1'b0;
      lfsr_d    = lfsr_next(lfsr_q);

      case (state_q)
         S_IDLE, S_DONE, S_FOUL: begin
            if (bus.start) begin
               state_d   = S_WAIT;
               delay_d   = DLY_W'(MIN_DELAY_MS) + DLY_W'(lfsr_q[10:0]);
               foul_d    = 1'b0;
               timeout_d = 1'b0;
               led_d     = 1'b0;
            end
         end
         S_WAIT: begin
            if (bus.react) begin
               state_d = S_FOUL;
               foul_d  = 1'b1;
               led_d   = 1'b0;
            end else if (tick) begin
               if (delay_q <= DLY_W'(1)) begin
                  state_d = S_ARMED;
                  led_d   = 1'b1;
                  time_d  = 16'h0000;
               end else begin
                  delay_d = delay_q - DLY_W'(1);
               end
            end
         end
         S_ARMED: begin
            if (bus.react) begin
               state_d = S_DONE;
               led_d   = 1'b0;
               rv_d    = 1'b1;
               // A zero reaction is treated as an anticipation and never becomes the best time.
               if ((time_q != 16'h0000) && (time_q < best_q)) begin
                  best_d = time_q;
               end
            end else if (tick) begin
               if (time_q == BCD_MAX) begin
                  state_d   = S_DONE;
                  led_d     = 1'b0;
                  timeout_d = 1'b1;
               end else begin
                  time_d = bcd_inc(time_q);
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            led_d   = 1'b0;
         end
      endcase

      // The prescaler restarts on every state change so each phase is an exact multiple of a ms.
      if (tick || (state_d != state_q)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         delay_q   <= '0;
         lfsr_q    <= LFSR_SEED;
         time_q    <= 16'h0000;
         best_q    <= BCD_MAX;
         led_q     <= 1'b0;
         foul_q    <= 1'b0;
         timeout_q <= 1'b0;
         rv_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         delay_q   <= delay_d;
         lfsr_q    <= lfsr_d;
         time_q    <= time_d;
         best_q    <= best_d;
         led_q     <= led_d;
         foul_q    <= foul_d;
         timeout_q <= timeout_d;
         rv_q      <= rv_d;
      end
   end

   assign bus.led          = led_q;
   assign bus.foul         = foul_q;
   assign bus.timeout      = timeout_q;
   assign bus.result_valid = rv_q;
   assign bus.time_bcd     = time_q;
   assign bus.best_bcd     = best_q;
   assign bus.state        = state_q;

endmodule

// File: tb/tb_reaction_ctrl.sv
// Bench for reaction_ctrl at TICKS_PER_MS=4, MIN_DELAY_MS=2: table of reaction trials
// plus hand-written sequences for fouls, timeout, coincident events and reset.
module tb_reaction_ctrl;

   localparam int TPM = 4;
   localparam int MIN = 2;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   reaction_ctrl_if bus();

   reaction_ctrl #(.TICKS_PER_MS(TPM), .MIN_DELAY_MS(MIN)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference LFSR so the bench knows the delay that a start pulse latches.
   logic [15:0] lfsr_m;
   always @(posedge clk or posedge reset) begin
      if (reset) lfsr_m <= 16'hACE1;
      else       lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
   end

   typedef struct packed {
      logic [15:0] t;
      logic [15:0] b;
   } exp_t;

   typedef struct {
      int          ticks;
      logic [15:0] t;
      logic [15:0] b;
   } vec_t;

   exp_t sb_q[$];
   vec_t vecs[4];
   int   total = 0;
   int   bad   = 0;
   logic rv_prev = 1'b0;
   int   d;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic mon();
      exp_t e;
      if (!reset) begin
         if (bus.result_valid) begin
            if (sb_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL rv_unexpected: result_valid got 1 expected 0 (time_bcd=%0h)", bus.time_bcd);
            end else begin
               e = sb_q.pop_front();
               check("rv_time", bus.time_bcd, e.t);
               check("rv_best", bus.best_bcd, e.b);
               check("rv_state", bus.state, 3);
            end
            if (rv_prev) begin
               total++;
               bad++;
               $display("FAIL rv_width: result_valid got 2+ cycles expected 1");
            end
         end
         rv_prev = bus.result_valid;
      end else begin
         rv_prev = 1'b0;
      end
   endtask

   task automatic step();
      @(negedge clk);
      mon();
   endtask

   // Waits until the reference LFSR low bits fall in [lo,hi], then pulses start.
   task automatic start_trial(input int lo, input int hi, input int bound, input logic with_react,
                              output int dly);
      int n = 0;
      while (!((int'(lfsr_m[10:0]) >= lo) && (int'(lfsr_m[10:0]) <= hi)) && (n < bound)) begin
         step();
         n++;
      end
      if (n >= bound) begin
         total++;
         bad++;
         $display("FAIL lfsr_wait: got %0d cycles expected < %0d", n, bound);
      end
      dly       = MIN + int'(lfsr_m[10:0]);
      bus.start = 1'b1;
      bus.react = with_react;
      step();
      bus.start = 1'b0;
      bus.react = 1'b0;
      check("enter_wait", bus.state, 1);
      check("wait_led", bus.led, 0);
   endtask

   task automatic wait_armed(input int exp_cycles, input string name);
      int n = 0;
      while ((bus.state == 3'd1) && (n < 9000)) begin
         step();
         n++;
      end
      if (exp_cycles >= 0) check(name, n, exp_cycles);
      check("armed_state", bus.state, 2);
      check("armed_led", bus.led, 1);
      check("armed_time", bus.time_bcd, 16'h0000);
   endtask

   task automatic do_react(input logic [15:0] exp_time, input logic [15:0] exp_best, input logic clr);
      sb_q.push_back('{t: exp_time, b: exp_best});
      bus.react      = 1'b1;
      bus.clear_best = clr;
      step();
      bus.react      = 1'b0;
      bus.clear_best = 1'b0;
      check("done_state", bus.state, 3);
      check("done_led", bus.led, 0);
      check("done_time", bus.time_bcd, exp_time);
      check("done_timeout", bus.timeout, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation got no finish expected one within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.start      = 1'b0;
      bus.react      = 1'b0;
      bus.clear_best = 1'b0;
      vecs[0] = '{13, 16'h0013, 16'h0013};
      vecs[1] = '{20, 16'h0020, 16'h0013};
      vecs[2] = '{9,  16'h0009, 16'h0009};
      vecs[3] = '{0,  16'h0000, 16'h0009};

      repeat (3) step();
      check("rst_state", bus.state, 0);
      check("rst_led", bus.led, 0);
      check("rst_foul", bus.foul, 0);
      check("rst_timeout", bus.timeout, 0);
      check("rst_rv", bus.result_valid, 0);
      check("rst_time", bus.time_bcd, 16'h0000);
      check("rst_best", bus.best_bcd, 16'h9999);
      reset = 1'b0;
      step();
      check("idle_after_release", bus.state, 0);

      // Table of reaction trials; the first one uses a latched delay of 2+3 ms.
      for (int i = 0; i < 4; i++) begin
         if (i == 0) start_trial(3, 3, 20000, 1'b0, d);
         else        start_trial(0, 3, 8000, 1'b0, d);
         wait_armed(TPM * d, "wait_len");
         repeat (TPM * vecs[i].ticks) step();
         do_react(vecs[i].t, vecs[i].b, 1'b0);
      end

      // Early react in WAIT, then start+react together in FOUL.
      start_trial(0, 3, 8000, 1'b0, d);
      repeat (2) step();
      bus.react = 1'b1;
      step();
      bus.react = 1'b0;
      check("foul_state", bus.state, 4);
      check("foul_flag", bus.foul, 1);
      check("foul_led", bus.led, 0);
      check("foul_best", bus.best_bcd, 16'h0009);
      start_trial(0, 3, 8000, 1'b1, d);
      check("foul_cleared", bus.foul, 0);

      // React on the expiry tick of WAIT still counts as a foul.
      repeat (TPM * d - 1) step();
      bus.react = 1'b1;
      step();
      bus.react = 1'b0;
      check("expiry_foul_state", bus.state, 4);
      check("expiry_foul_led", bus.led, 0);

      // Start during WAIT is ignored, then run ARMED to saturation.
      start_trial(0, 3, 8000, 1'b0, d);
      check("foul_cleared2", bus.foul, 0);
      repeat (3) step();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      wait_armed(TPM * d - 4, "wait_len_start_ignored");
      for (int j = 1; j <= TPM * 10000; j++) begin
         step();
         if (j == 3)     check("no_early_inc", bus.time_bcd, 16'h0000);
         if (j == 4)     check("first_inc", bus.time_bcd, 16'h0001);
         if (j == 396)   check("cnt_0099", bus.time_bcd, 16'h0099);
         if (j == 400)   check("carry_0100", bus.time_bcd, 16'h0100);
         if (j == 3996)  check("cnt_0999", bus.time_bcd, 16'h0999);
         if (j == 4000)  check("carry_1000", bus.time_bcd, 16'h1000);
         if (j == 39996) check("cnt_9999", bus.time_bcd, 16'h9999);
         if (j == 39999) check("still_armed", bus.state, 2);
      end
      check("to_state", bus.state, 3);
      check("to_flag", bus.timeout, 1);
      check("to_time", bus.time_bcd, 16'h9999);
      check("to_rv", bus.result_valid, 0);
      check("to_led", bus.led, 0);
      check("to_best", bus.best_bcd, 16'h0009);
      start_trial(0, 3, 8000, 1'b0, d);
      check("to_cleared", bus.timeout, 0);

      // React coincident with a tick at 0041 keeps the un-incremented time.
      wait_armed(TPM * d, "wait_len");
      repeat (TPM * 41 + 3) step();
      do_react(16'h0041, 16'h0009, 1'b0);

      // Asynchronous reset while ARMED at 0057.
      start_trial(0, 3, 8000, 1'b0, d);
      wait_armed(TPM * d, "wait_len");
      repeat (TPM * 57) step();
      check("pre_reset_time", bus.time_bcd, 16'h0057);
      #2 reset = 1'b1;
      #1;
      check("arst_state", bus.state, 0);
      check("arst_led", bus.led, 0);
      check("arst_time", bus.time_bcd, 16'h0000);
      check("arst_best", bus.best_bcd, 16'h9999);
      check("arst_foul", bus.foul, 0);
      step();
      reset = 1'b0;

      // clear_best coincident with an update, then clear_best alone.
      start_trial(0, 3, 8000, 1'b0, d);
      wait_armed(TPM * d, "wait_len");
      repeat (TPM * 5) step();
      do_react(16'h0005, 16'h0005, 1'b1);
      bus.clear_best = 1'b1;
      step();
      bus.clear_best = 1'b0;
      check("clear_best", bus.best_bcd, 16'h9999);
      check("clear_keeps_state", bus.state, 3);
      check("clear_keeps_time", bus.time_bcd, 16'h0005);

      check("sb_empty", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
